// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding and time-base helpers for stopwatch_ctrl
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_LAP   = 2'b11;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // At least one bit so a DIV of 2 still gets a usable register.
    function automatic int presc_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// rtl/stopwatch_tick_prescaler.sv - divide-by-DIV prescaler with hold and clear
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = presc_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // tick marks the cycle in which a period completes; the caller registers it.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap control FSM and 1 kHz enable for the ms counter
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clr,
    input  logic [CNT_W-1:0] nrms,
    output logic             ms,
    output logic             cnt_rst,
    output logic [CNT_W-1:0] lap_val,
    output logic             lap_valid,
    output logic             running,
    output logic             ovf,
    output logic [1:0]       state
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    generate
        if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
            $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
    endgenerate

    logic [1:0] state_q;
    logic       run_en;
    logic       tick_due;
    logic       presc_clr;
    logic       at_max;
    logic       ovf_evt;

    assign run_en    = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign presc_clr = ((state_q == ST_IDLE) && start_stop) ||
                       ((state_q == ST_PAUSE) && clr);
    assign at_max    = &nrms;
    // A due tick against a saturated counter is swallowed so it never wraps.
    assign ovf_evt   = tick_due && at_max;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (presc_clr),
        .tick (tick_due)
    );

    assign state   = state_q;
    assign running = run_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ms        <= 1'b0;
            cnt_rst   <= 1'b1;
            lap_val   <= '0;
            lap_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ms      <= tick_due && !at_max;
            cnt_rst <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        cnt_rst <= 1'b1;
                    end else if (start_stop) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN, ST_LAP: begin
                    if (ovf_evt) begin
                        ovf       <= 1'b1;
                        state_q   <= ST_PAUSE;
                        lap_valid <= 1'b0;
                    end else if (start_stop) begin
                        state_q   <= ST_PAUSE;
                        lap_valid <= 1'b0;
                    end else if (lap) begin
                        lap_val   <= nrms;
                        lap_valid <= 1'b1;
                        state_q   <= ST_LAP;
                    end
                end
                default: begin
                    if (clr) begin
                        cnt_rst   <= 1'b1;
                        lap_val   <= '0;
                        lap_valid <= 1'b0;
                        ovf       <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (start_stop) begin
                        state_q <= ST_RUN;
                    end else if (lap) begin
                        lap_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
